// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: execute-stage ALU with valid/ready handshake and an
// iterative radix-2 RV32M multiply/divide datapath.
//
// Ports:
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   PC_IN, RS1_IN       operand A candidates (MUX1_CTRL: 0 = RS1_IN, 1 = PC_IN)
//   RS2_IN, IMM_IN      operand B candidates (MUX2_CTRL: 0 = RS2_IN, 1 = IMM_IN)
//   ALU_CTRL            opcode (0-9 integer ops, 10-13 multiply, 14-17 divide,
//                       18+ single-cycle zero)
//   IN_VALID/IN_READY   request handshake; IN_READY only in IDLE
//   FLUSH               synchronous abort, highest priority
//   ALU_OUT/OUT_VALID   registered result, held until OUT_READY
//   OUT_READY           consumer accepts the result
//   BUSY                a multiply or divide is iterating
module alu_seq_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_WIDTH = 5,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] PC_IN,
  input  logic [DATA_WIDTH-1:0] RS1_IN,
  input  logic [DATA_WIDTH-1:0] RS2_IN,
  input  logic [DATA_WIDTH-1:0] IMM_IN,
  input  logic [FUNC_WIDTH-1:0] ALU_CTRL,
  input  logic                  MUX1_CTRL,
  input  logic                  MUX2_CTRL,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY
);

  localparam int W = DATA_WIDTH;

  localparam logic [FUNC_WIDTH-1:0] OP_ADD    = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] OP_SUB    = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] OP_SLL    = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] OP_SLT    = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] OP_SLTU   = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] OP_XOR    = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] OP_SRL    = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] OP_SRA    = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] OP_OR     = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] OP_AND    = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] OP_MUL    = FUNC_WIDTH'(10);
  localparam logic [FUNC_WIDTH-1:0] OP_MULH   = FUNC_WIDTH'(11);
  localparam logic [FUNC_WIDTH-1:0] OP_MULHSU = FUNC_WIDTH'(12);
  localparam logic [FUNC_WIDTH-1:0] OP_MULHU  = FUNC_WIDTH'(13);
  localparam logic [FUNC_WIDTH-1:0] OP_DIV    = FUNC_WIDTH'(14);
  localparam logic [FUNC_WIDTH-1:0] OP_REM    = FUNC_WIDTH'(16);
  localparam logic [FUNC_WIDTH-1:0] OP_REMU   = FUNC_WIDTH'(17);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state;
  logic [SHAMT_W-1:0]   count;
  logic [W-1:0]         alu_out;

  logic [W-1:0]         opa;
  logic [W-1:0]         opb;
  logic                 accept;
  logic                 is_mul;
  logic                 is_div;

  // Iteration registers (not reset: only meaningful while state says so)
  logic [2*W-1:0]       mcand_p0;
  logic [W-1:0]         mplier_p0;
  logic [2*W-1:0]       prod_p0;
  logic                 mul_neg_p0;
  logic                 mul_hi_p0;
  logic [W-1:0]         quo_p0;
  logic [W-1:0]         rem_p0;
  logic [W-1:0]         dvs_p0;
  logic                 neg_q_p0;
  logic                 neg_r_p0;
  logic                 sel_rem_p0;

  logic [2*W-1:0]       prod_nx;
  logic [2*W-1:0]       mul_full;
  logic [W-1:0]         mul_res;
  logic [W:0]           rem_sh;
  logic                 rem_ge;
  logic [W-1:0]         rem_diff;
  logic [W-1:0]         rem_nx;
  logic [W-1:0]         quo_nx;
  logic [W-1:0]         div_res;

  function automatic logic [W-1:0] exec_simple(input logic [FUNC_WIDTH-1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [SHAMT_W-1:0]  sh;
    sa = a;
    sb = b;
    sh = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  exec_simple = a + b;
      OP_SUB:  exec_simple = a - b;
      OP_SLL:  exec_simple = a << sh;
      OP_SLT:  exec_simple = {{(W-1){1'b0}}, (sa < sb)};
      OP_SLTU: exec_simple = {{(W-1){1'b0}}, (a < b)};
      OP_XOR:  exec_simple = a ^ b;
      OP_SRL:  exec_simple = a >> sh;
      OP_SRA:  exec_simple = $unsigned(sa >>> sh);
      OP_OR:   exec_simple = a | b;
      OP_AND:  exec_simple = a & b;
      default: exec_simple = '0;
    endcase
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
    magnitude = (is_signed && x[W-1]) ? -x : x;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] x, input logic neg);
    apply_sign = neg ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] apply_sign_wide(input logic [2*W-1:0] x, input logic neg);
    apply_sign_wide = neg ? -x : x;
  endfunction

  assign opa      = MUX1_CTRL ? PC_IN : RS1_IN;
  assign opb      = MUX2_CTRL ? IMM_IN : RS2_IN;
  assign IN_READY = (state == S_IDLE) && !RST;
  assign accept   = IN_VALID && IN_READY && !FLUSH;
  assign is_mul   = (ALU_CTRL >= OP_MUL) && (ALU_CTRL <= OP_MULHU);
  assign is_div   = (ALU_CTRL >= OP_DIV) && (ALU_CTRL <= OP_REMU);

  // Next-iteration values; the final iteration also folds in the sign fix-up
  // so the corrected result lands in ALU_OUT on the transition to DONE.
  always_comb begin
    prod_nx  = prod_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    mul_full = apply_sign_wide(prod_nx, mul_neg_p0);
    mul_res  = mul_hi_p0 ? mul_full[2*W-1:W] : mul_full[W-1:0];

    // Restoring step: remainder is always below the divisor, so the shifted
    // value needs one extra bit and the difference fits back into W bits.
    rem_sh   = {rem_p0, quo_p0[W-1]};
    rem_ge   = rem_sh >= {1'b0, dvs_p0};
    rem_diff = rem_sh[W-1:0] - dvs_p0;
    rem_nx   = rem_ge ? rem_diff : rem_sh[W-1:0];
    quo_nx   = {quo_p0[W-2:0], rem_ge};
    div_res  = sel_rem_p0 ? apply_sign(rem_nx, neg_r_p0) : apply_sign(quo_nx, neg_q_p0);
  end

  // Stage p0: operand capture at accept, then one radix-2 step per cycle
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && accept) begin
      if (is_mul) begin
        // MUL's low word is sign-agnostic, so only MULH/MULHSU take magnitudes.
        mcand_p0   <= {{W{1'b0}}, magnitude(opa, (ALU_CTRL == OP_MULH) || (ALU_CTRL == OP_MULHSU))};
        mplier_p0  <= magnitude(opb, ALU_CTRL == OP_MULH);
        prod_p0    <= '0;
        mul_neg_p0 <= (((ALU_CTRL == OP_MULH) || (ALU_CTRL == OP_MULHSU)) && opa[W-1]) ^
                      ((ALU_CTRL == OP_MULH) && opb[W-1]);
        mul_hi_p0  <= (ALU_CTRL != OP_MUL);
      end
      if (is_div) begin
        quo_p0     <= magnitude(opa, (ALU_CTRL == OP_DIV) || (ALU_CTRL == OP_REM));
        dvs_p0     <= magnitude(opb, (ALU_CTRL == OP_DIV) || (ALU_CTRL == OP_REM));
        rem_p0     <= '0;
        // A zero divisor must leave the all-ones quotient uncorrected.
        neg_q_p0   <= ((ALU_CTRL == OP_DIV) && (opa[W-1] ^ opb[W-1]) && (opb != '0));
        neg_r_p0   <= ((ALU_CTRL == OP_REM) && opa[W-1]);
        sel_rem_p0 <= (ALU_CTRL >= OP_REM);
      end
    end else if (state == S_MUL) begin
      prod_p0   <= prod_nx;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end else if (state == S_DIV) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

  // Stage p1: control FSM and registered result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      count   <= '0;
      alu_out <= '0;
    end else if (FLUSH) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            count <= '0;
            if (is_mul) begin
              state <= S_MUL;
            end else if (is_div) begin
              state <= S_DIV;
            end else begin
              alu_out <= exec_simple(ALU_CTRL, opa, opb);
              state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          count <= count + 1'b1;
          if (count == SHAMT_W'(W-1)) begin
            alu_out <= mul_res;
            state   <= S_DONE;
          end
        end
        S_DIV: begin
          count <= count + 1'b1;
          if (count == SHAMT_W'(W-1)) begin
            alu_out <= div_res;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (OUT_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ALU_OUT   = alu_out;
  assign OUT_VALID = (state == S_DONE);
  assign BUSY      = (state == S_MUL) || (state == S_DIV);

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Testbench for alu_seq_muldiv: directed plan items plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_seq_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0, rs1_in = '0, rs2_in = '0, imm_in = '0;
  logic [4:0]  alu_ctrl = '0;
  logic        mux1 = 1'b0, mux2 = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_seq_muldiv #(.DATA_WIDTH(32), .FUNC_WIDTH(5)) dut (
    .CLK(clk), .RST(rst), .PC_IN(pc_in), .RS1_IN(rs1_in), .RS2_IN(rs2_in),
    .IMM_IN(imm_in), .ALU_CTRL(alu_ctrl), .MUX1_CTRL(mux1), .MUX2_CTRL(mux2),
    .IN_VALID(in_valid), .IN_READY(in_ready), .FLUSH(flush), .ALU_OUT(alu_out),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return $unsigned($signed(a) >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = sa * sb;  return p[31:0];  end
      5'd11: begin p = sa * sb;  return p[63:32]; end
      5'd12: begin p = sa * longint'(ub); return p[63:32]; end
      5'd13: begin p = ua * ub;  return p[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      5'd17: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] op);
    return (op >= 5'd10 && op <= 5'd17) ? 33 : 1;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request in IDLE, scramble the inputs after the accept edge,
  // and wait (bounded) for the result. Leaves the unit back in IDLE.
  task automatic do_op(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic m1,
                       input logic m2, output logic [31:0] res, output int lat,
                       output int busy_cnt);
    @(negedge clk);
    alu_ctrl = op; rs1_in = rs1; rs2_in = rs2; imm_in = imm; pc_in = pc;
    mux1 = m1; mux2 = m2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1_in = $urandom; rs2_in = $urandom; imm_in = $urandom; pc_in = $urandom;
    alu_ctrl = 5'($urandom); mux1 = ~m1; mux2 = ~m2;
    lat = 1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    res = alu_out;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] res, held, a, b, rs1, rs2, imm, pc;
    logic [4:0]  op;
    logic        m1, m2;
    int          lat, bc, seen;

    // Reset: an IN_VALID during reset must not be accepted.
    alu_ctrl = 5'd0; rs1_in = 32'd5; rs2_in = 32'd6; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single-cycle ops
    do_op(5'd0, 32'd20, 32'd30, 32'd40, 32'd10, 1'b0, 1'b0, res, lat, bc);
    check("add_rs1_rs2", res, 32'd50);
    check("add_latency", lat, 32'd1);
    do_op(5'd0, 32'd20, 32'd30, 32'd40, 32'd10, 1'b1, 1'b0, res, lat, bc);
    check("add_pc_rs2", res, 32'd40);
    do_op(5'd0, 32'd20, 32'd30, 32'd40, 32'd10, 1'b0, 1'b1, res, lat, bc);
    check("add_rs1_imm", res, 32'd60);
    do_op(5'd1, 32'd20, 32'd30, 32'd40, 32'd10, 1'b0, 1'b0, res, lat, bc);
    check("sub", res, 32'hFFFF_FFF6);
    do_op(5'd3, 32'd20, -32'sd30, 32'd40, 32'd10, 1'b0, 1'b0, res, lat, bc);
    check("slt_neg", res, 32'd0);
    do_op(5'd4, 32'd20, -32'sd30, 32'd40, 32'd10, 1'b0, 1'b0, res, lat, bc);
    check("sltu_neg", res, 32'd1);

    // Multiply
    do_op(5'd11, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("mulh_min_min", res, 32'h4000_0000);
    check("mul_latency", lat, 32'd33);
    check("mul_busy_cycles", bc, 32'd32);
    do_op(5'd10, -32'sd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("mul_neg7_6", res, 32'hFFFF_FFD6);
    do_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("mulhu_ones", res, 32'hFFFF_FFFE);

    // Divide
    do_op(5'd14, -32'sd20, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("div_neg20_3", res, 32'hFFFF_FFFA);
    check("div_latency", lat, 32'd33);
    do_op(5'd16, -32'sd20, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("rem_neg20_3", res, 32'hFFFF_FFFE);
    do_op(5'd15, 32'd20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("divu_by_zero", res, 32'hFFFF_FFFF);
    check("divu_zero_latency", lat, 32'd33);
    do_op(5'd17, 32'd20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("remu_by_zero", res, 32'd20);
    do_op(5'd14, -32'sd20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("div_neg_by_zero", res, 32'hFFFF_FFFF);
    do_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("div_overflow", res, 32'h8000_0000);
    do_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("rem_overflow", res, 32'd0);

    // Back-pressure: DIVU 100/7 held for 5 cycles while a new request waits.
    out_ready = 1'b0;
    do_op(5'd15, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, held, lat, bc);
    check("bp_result", held, 32'd14);
    @(negedge clk);
    alu_ctrl = 5'd0; rs1_in = 32'd1; rs2_in = 32'd1; mux1 = 1'b0; mux2 = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_out", alu_out, 32'd14);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_no_ghost", {31'b0, out_valid}, 32'd0);

    // FLUSH together with IN_VALID in IDLE: request dropped.
    @(negedge clk);
    alu_ctrl = 5'd0; rs1_in = 32'd3; rs2_in = 32'd4; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush_same_cycle_valid", {31'b0, out_valid}, 32'd0);
    check("flush_same_cycle_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    // FLUSH at DIV iteration 10
    @(negedge clk);
    alu_ctrl = 5'd14; rs1_in = 32'd1000; rs2_in = 32'd7; mux1 = 1'b0; mux2 = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_div_ready", {31'b0, in_ready}, 32'd1);
    check("flush_div_busy", {31'b0, busy}, 32'd0);
    check("flush_div_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush_div_no_result", seen, 32'd0);
    do_op(5'd0, 32'd7, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("add_after_flush", res, 32'd15);
    check("add_after_flush_lat", lat, 32'd1);

    // Asynchronous reset mid-MUL
    @(negedge clk);
    alu_ctrl = 5'd10; rs1_in = 32'd9; rs2_in = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_mul_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_out", alu_out, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("async_rst_no_result", seen, 32'd0);

    // Opcode 20 yields zero in one cycle
    do_op(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, 1'b0, res, lat, bc);
    check("op20_result", res, 32'd0);
    check("op20_latency", lat, 32'd1);

    // Back-to-back: IN_VALID and OUT_READY held high -> result every 2 cycles
    @(negedge clk);
    alu_ctrl = 5'd0; rs1_in = 32'd1; rs2_in = 32'd2; mux1 = 1'b0; mux2 = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("b2b_valid", {31'b0, out_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      op  = 5'($urandom_range(0, 31));
      rs1 = rand_val(); rs2 = rand_val(); imm = rand_val(); pc = rand_val();
      m1  = 1'($urandom_range(0, 1));
      m2  = 1'($urandom_range(0, 1));
      a   = m1 ? pc : rs1;
      b   = m2 ? imm : rs2;
      do_op(op, rs1, rs2, imm, pc, m1, m2, res, lat, bc);
      check($sformatf("rand_op%0d_res", op), res, ref_model(op, a, b));
      check($sformatf("rand_op%0d_lat", op), lat, exp_latency(op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Keeps the operand-select muxes: PC or RS1 for operand A, RS2 or IMM for operand B.
- Adds registered results, valid/ready flow control, and RV32M multiply/divide using a radix-2 iterative datapath.
- Sits in the execute stage between the decode/issue register and writeback.

Parameters:
DATA_WIDTH  32  operand/result width; must be a power of 2, at least 8
FUNC_WIDTH  5   width of ALU_CTRL
SHAMT_W     $clog2(DATA_WIDTH)  derived; only the low bits of operand B are used for shifts

Ports:
CLK        in   1           clock, rising edge
RST        in   1           asynchronous, active-high reset
PC_IN      in   DATA_WIDTH  program counter operand
RS1_IN     in   DATA_WIDTH  register source 1
RS2_IN     in   DATA_WIDTH  register source 2
IMM_IN     in   DATA_WIDTH  immediate
ALU_CTRL   in   FUNC_WIDTH  operation code
MUX1_CTRL  in   1           operand A select: 0 = RS1_IN, 1 = PC_IN
MUX2_CTRL  in   1           operand B select: 0 = RS2_IN, 1 = IMM_IN
IN_VALID   in   1           request valid
IN_READY   out  1           unit can accept a request
FLUSH      in   1           synchronous abort
ALU_OUT    out  DATA_WIDTH  registered result
OUT_VALID  out  1           ALU_OUT is valid
OUT_READY  in   1           consumer accepts the result
BUSY       out  1           a multi-cycle operation is in progress

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL (low word), 11 MULH (s*s), 12 MULHSU (s*u), 13 MULHU (u*u).
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Codes 18 and above: single-cycle op with result 0.
- Operand capture:
  - A request is accepted on a rising edge when IN_VALID and IN_READY are both 1.
  - A, B and ALU_CTRL are registered at acceptance; later changes on the inputs have no effect.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: IN_READY = 1. On accept, opcodes 0-9 and 18+ go to DONE with the result registered (latency 1). Opcodes 10-13 go to MUL; 14-17 go to DIV.
  - MUL: shift-add over unsigned magnitudes with a 2*DATA_WIDTH product register. Signs are fixed at entry and exit. Exactly DATA_WIDTH cycles, then DONE.
  - DIV: restoring divide on magnitudes. Exactly DATA_WIDTH cycles, then DONE with the sign correction applied on that transition.
  - DONE: OUT_VALID = 1 and ALU_OUT is held stable. When OUT_READY = 1 the result is consumed and the FSM returns to IDLE.
- Latencies (accept edge to OUT_VALID rise):
  - Single-cycle ops: 1 cycle.
  - Mul/div ops: DATA_WIDTH + 1 cycles.
- Derived outputs:
  - IN_READY = (state == IDLE); there is no overlap or pipelining.
  - BUSY = state is MUL or DIV.
- Division corner cases:
  - Divide by zero: DIV and DIVU return all-ones; REM and REMU return the dividend. The operation still takes the full latency.
  - Signed overflow (min-negative / -1): DIV returns the dividend; REM returns 0.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^DATA_WIDTH.
  - Shifts use B[SHAMT_W-1:0].
  - SLT and SLTU return 1 or 0, zero-extended.
- FLUSH:
  - Has priority over all other transitions: next state is IDLE and OUT_VALID goes to 0.
  - An IN_VALID arriving in the same cycle as FLUSH is not accepted.
- Reset:
  - Reset values: state IDLE, OUT_VALID 0, ALU_OUT 0, BUSY 0, IN_READY 1 once RST is released.
  - Reset takes effect immediately, including mid-iteration, and the partial result is discarded.
  - No request is accepted while RST is high.
- Back-pressure: OUT_READY = 0 in DONE holds ALU_OUT and OUT_VALID indefinitely.
- OUT_READY outside DONE is ignored.

Test Plan:
1. Single-cycle ops: RS1=20, RS2=30, IMM=40, PC=10.
   - ADD with MUX1=0, MUX2=0 -> 50.
   - ADD with MUX1=1 -> 40.
   - ADD with MUX2=1 -> 60.
   - SUB -> 0xFFFFFFF6.
   - SLT with RS2=-30 -> 0; SLTU with RS2=-30 -> 1.
   - OUT_VALID rises 1 cycle after the accept edge.
2. Multiply:
   - MULH with 0x80000000 * 0x80000000 -> 0x40000000.
   - MUL with -7 * 6 -> 0xFFFFFFD6.
   - MULHU with 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
   - OUT_VALID rises exactly 33 cycles after accept; BUSY is high for 32 cycles.
3. Divide:
   - DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE.
   - DIVU 20/0 -> 0xFFFFFFFF; REMU 20/0 -> 20.
   - DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
4. Back-pressure: hold OUT_READY=0 for 5 cycles after OUT_VALID rises.
   - ALU_OUT is stable, IN_READY=0, and a new IN_VALID is not accepted.
   - OUT_READY=1 for one cycle -> IDLE on the next edge.
5. Abort during DIV:
   - FLUSH at iteration 10 -> IDLE next edge with no OUT_VALID; a following ADD completes normally.
   - Asynchronous RST pulse mid-MUL -> outputs return to their reset values immediately, without waiting for a CLK edge.
6. Opcode 20 -> ALU_OUT=0 with 1-cycle latency. Back-to-back accepts -> one result every 2 cycles with OUT_READY held at 1.
